// File: rtl/score_counter.sv
// score_counter: queues BCD point events and folds them one digit per cycle
// into a shadow score, then commits all four displayed digits on one edge.
//
// Handshake: an event is taken on a rising clk edge when add_valid=1 and
// add_ready=1 (and clear=0); add_valid with add_ready=0 is lost and sets
// the sticky dropped flag. add_valid is a strobe, not held until ready.
module score_counter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       add_valid,
  input  logic [3:0] add_ones,
  input  logic [3:0] add_tens,
  output logic       add_ready,
  output logic [4:0] ones,
  output logic [4:0] tens,
  output logic [4:0] hundreds,
  output logic [4:0] thousands,
  output logic       busy,
  output logic       saturated,
  output logic       dropped,
  output logic [2:0] state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ADD0, S_ADD1, S_ADD2, S_ADD3, S_COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [7:0]    head;

  logic [1:0][3:0] op_q, op_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            sat_q, sat_d;
  logic            drop_q, drop_d;

  logic [1:0] add_idx;
  logic       add_en;
  logic [3:0] opnd;
  logic [4:0] sum;
  logic [3:0] digit;
  logic       cout;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign add_ready = (count_q != CW'(FIFO_DEPTH));
  assign busy      = (state_q != S_IDLE) || (count_q != '0);
  assign push      = add_valid && add_ready && !clear;
  assign pop       = (state_q == S_LOAD) && !clear;
  assign head      = mem_q[rd_ptr_q];

  assign ones      = {1'b0, dig_q[0]};
  assign tens      = {1'b0, dig_q[1]};
  assign hundreds  = {1'b0, dig_q[2]};
  assign thousands = {1'b0, dig_q[3]};
  assign saturated = sat_q;
  assign dropped   = drop_q;
  assign state_dbg = state_q;

  // Event storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {clamp9(add_tens), clamp9(add_ones)};
  end

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; clear flushes the queue.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Sequencer: load one event, add four digits, commit, then wait again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_LOAD;
      S_LOAD:   state_d = S_ADD0;
      S_ADD0:   state_d = S_ADD1;
      S_ADD1:   state_d = S_ADD2;
      S_ADD2:   state_d = S_ADD3;
      S_ADD3:   state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // BCD datapath: one digit per ADD state, shadow copy kept off the outputs.
  always_comb begin
    op_d    = op_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    drop_d  = drop_q;
    add_idx = 2'd0;
    add_en  = 1'b0;
    case (state_q)
      S_ADD0:  begin add_en = 1'b1; add_idx = 2'd0; end
      S_ADD1:  begin add_en = 1'b1; add_idx = 2'd1; end
      S_ADD2:  begin add_en = 1'b1; add_idx = 2'd2; end
      S_ADD3:  begin add_en = 1'b1; add_idx = 2'd3; end
      default: begin add_en = 1'b0; add_idx = 2'd0; end
    endcase
    // Event amounts only cover ones and tens; upper digits add carry only.
    opnd = add_idx[1] ? 4'd0 : op_q[add_idx[0]];
    sum  = {1'b0, sh_q[add_idx]} + {1'b0, opnd} + {4'd0, carry_q};
    if (sum > 5'd9) begin
      digit = sum[3:0] - 4'd10;
      cout  = 1'b1;
    end else begin
      digit = sum[3:0];
      cout  = 1'b0;
    end

    if (state_q == S_LOAD) begin
      op_d    = head;
      sh_d    = dig_q;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end
    if (add_en) begin
      sh_d[add_idx] = digit;
      carry_d       = cout;
      if (state_q == S_ADD3 && cout) ovf_d = 1'b1;
    end
    if (state_q == S_COMMIT) begin
      if (ovf_q || sat_q) begin
        dig_d = {4'd9, 4'd9, 4'd9, 4'd9};
        sat_d = 1'b1;
      end else begin
        dig_d = sh_q;
      end
    end
    if (add_valid && !add_ready) drop_d = 1'b1;
    if (clear) begin
      dig_d  = '0;
      sat_d  = 1'b0;
      drop_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_q    <= '0;
      sh_q    <= '0;
      dig_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: each scenario task drives events and
// checks the committed digits and flags against hand-computed values.
module tb_score_counter;

  logic       clk;
  logic       resetN;
  logic       clear;
  logic       add_valid;
  logic [3:0] add_ones;
  logic [3:0] add_tens;
  logic       add_ready;
  logic [4:0] ones, tens, hundreds, thousands;
  logic       busy, saturated, dropped;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] score;
  assign score = {thousands, hundreds, tens, ones};

  score_counter #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (clear),
    .add_valid (add_valid),
    .add_ones  (add_ones),
    .add_tens  (add_tens),
    .add_ready (add_ready),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .busy      (busy),
    .saturated (saturated),
    .dropped   (dropped),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [19:0] dig(input int th, input int h, input int t, input int o);
    return {5'(th), 5'(h), 5'(t), 5'(o)};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] t, input logic [3:0] o);
    add_valid = 1'b1;
    add_tens  = t;
    add_ones  = o;
    step();
    add_valid = 1'b0;
  endtask

  task automatic add_and_wait(input logic [3:0] t, input logic [3:0] o);
    push(t, o);
    repeat (7) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    n_checks++;
    if (score !== dig(0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_score: got %h expected %h", score, dig(0, 0, 0, 0));
    end
    n_checks++;
    if ({add_ready, busy, saturated, dropped} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1000", {add_ready, busy, saturated, dropped});
    end
  endtask

  task automatic test_add15();
    push(4'd1, 4'd5);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL add15_busy: got %b expected 1", busy);
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      n_checks++;
      if (score !== dig(0, 0, 0, 0)) begin
        n_fail++; $display("FAIL add15_early E%0d: got %h expected %h", c, score, dig(0, 0, 0, 0));
      end
    end
    step();
    n_checks++;
    if (score !== dig(0, 0, 1, 5)) begin
      n_fail++; $display("FAIL add15_commit: got %h expected %h", score, dig(0, 0, 1, 5));
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL add15_busy_fall: got %b expected 0", busy);
    end
  endtask

  task automatic test_carry_ripple();
    do_clear();
    for (int i = 0; i < 10; i++) add_and_wait(4'd9, 4'd9);
    add_and_wait(4'd0, 4'd5);
    n_checks++;
    if (score !== dig(0, 9, 9, 5)) begin
      n_fail++; $display("FAIL carry_setup: got %h expected %h", score, dig(0, 9, 9, 5));
    end
    push(4'd0, 4'd5);
    for (int c = 1; c <= 6; c++) begin
      step();
      n_checks++;
      if (score !== dig(0, 9, 9, 5)) begin
        n_fail++; $display("FAIL carry_hold E%0d: got %h expected %h", c, score, dig(0, 9, 9, 5));
      end
    end
    step();
    n_checks++;
    if (score !== dig(1, 0, 0, 0)) begin
      n_fail++; $display("FAIL carry_commit: got %h expected %h", score, dig(1, 0, 0, 0));
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 100; i++) add_and_wait(4'd9, 4'd9);
    add_and_wait(4'd9, 4'd0);
    n_checks++;
    if (score !== dig(9, 9, 9, 0) || saturated !== 1'b0) begin
      n_fail++; $display("FAIL sat_setup: got %h sat %b expected %h sat 0", score, saturated, dig(9, 9, 9, 0));
    end
    add_and_wait(4'd2, 4'd5);
    n_checks++;
    if (score !== dig(9, 9, 9, 9) || saturated !== 1'b1) begin
      n_fail++; $display("FAIL sat_clamp: got %h sat %b expected %h sat 1", score, saturated, dig(9, 9, 9, 9));
    end
    add_and_wait(4'd0, 4'd1);
    n_checks++;
    if (score !== dig(9, 9, 9, 9) || saturated !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold: got %h sat %b expected %h sat 1", score, saturated, dig(9, 9, 9, 9));
    end
    do_clear();
    n_checks++;
    if (score !== dig(0, 0, 0, 0) || saturated !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: got %h sat %b expected %h sat 0", score, saturated, dig(0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_rdy;
    exp_rdy = 6'b001111;
    add_valid = 1'b1;
    add_tens  = 4'd0;
    add_ones  = 4'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (add_ready !== exp_rdy[i]) begin
        n_fail++; $display("FAIL burst_ready E%0d: got %b expected %b", i, add_ready, exp_rdy[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (dropped !== 1'b0) begin
          n_fail++; $display("FAIL burst_dropped_early: got %b expected 0", dropped);
        end
      end
    end
    add_valid = 1'b0;
    n_checks++;
    if (dropped !== 1'b1) begin
      n_fail++; $display("FAIL burst_dropped: got %b expected 1", dropped);
    end
    repeat (40) step();
    n_checks++;
    if (score !== dig(0, 0, 0, 5) || busy !== 1'b0) begin
      n_fail++; $display("FAIL burst_score: got %h busy %b expected %h busy 0", score, busy, dig(0, 0, 0, 5));
    end
  endtask

  task automatic test_clear_mid_add();
    add_valid = 1'b1;
    add_tens  = 4'd0;
    add_ones  = 4'd1;
    step();
    step();
    step();
    add_valid = 1'b0;
    step();
    n_checks++;
    if (state_dbg !== 3'd3) begin
      n_fail++; $display("FAIL clrmid_state_add1: got %0d expected 3", state_dbg);
    end
    do_clear();
    n_checks++;
    if (score !== dig(0, 0, 0, 0) || state_dbg !== 3'd0 || busy !== 1'b0 || add_ready !== 1'b1 || dropped !== 1'b0) begin
      n_fail++; $display("FAIL clrmid_after: got score %h state %0d busy %b ready %b dropped %b expected 0 0 0 1 0",
                         score, state_dbg, busy, add_ready, dropped);
    end
    repeat (10) step();
    n_checks++;
    if (score !== dig(0, 0, 0, 0) || busy !== 1'b0) begin
      n_fail++; $display("FAIL clrmid_stale: got %h busy %b expected %h busy 0", score, busy, dig(0, 0, 0, 0));
    end
  endtask

  task automatic test_clamp();
    clear     = 1'b1;
    add_valid = 1'b1;
    add_tens  = 4'd0;
    add_ones  = 4'd1;
    step();
    clear     = 1'b0;
    add_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || dropped !== 1'b0) begin
      n_fail++; $display("FAIL clear_ignores_add: got busy %b dropped %b expected 0 0", busy, dropped);
    end
    repeat (8) step();
    n_checks++;
    if (score !== dig(0, 0, 0, 0)) begin
      n_fail++; $display("FAIL clear_ignores_add_score: got %h expected %h", score, dig(0, 0, 0, 0));
    end
    add_and_wait(4'd10, 4'd12);
    n_checks++;
    if (score !== dig(0, 0, 9, 9)) begin
      n_fail++; $display("FAIL clamp: got %h expected %h", score, dig(0, 0, 9, 9));
    end
  endtask

  task automatic test_reset_mid();
    push(4'd0, 4'd1);
    repeat (3) step();
    #2 resetN = 1'b0;
    #1;
    n_checks++;
    if (score !== dig(0, 0, 0, 0) || busy !== 1'b0 || saturated !== 1'b0 || add_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: got score %h busy %b sat %b ready %b expected 0 0 0 1",
                         score, busy, saturated, add_ready);
    end
    #1 resetN = 1'b1;
    repeat (10) step();
    n_checks++;
    if (score !== dig(0, 0, 0, 0) || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_lost: got %h busy %b expected %h busy 0", score, busy, dig(0, 0, 0, 0));
    end
  endtask

  initial begin
    resetN    = 1'b0;
    clear     = 1'b0;
    add_valid = 1'b0;
    add_ones  = 4'd0;
    add_tens  = 4'd0;
    #12;
    test_reset();
    resetN = 1'b1;
    step();
    test_add15();
    test_carry_ripple();
    test_saturation();
    test_back_to_back();
    test_clear_mid_add();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_counter.md
# score_counter

Accumulates game points into a 4-digit decimal score and presents it as per-digit values for the on-screen score renderer. Point events from game logic (brick hits, coins, bonuses) are queued in a small FIFO. A digit-serial BCD adder applies each event to a shadow copy of the score and then commits the whole result at once, so the displayed digits never show a partially carried value. The block sits directly upstream of the score drawing stage, and its digit outputs connect straight to that stage's ones/tens/hundreds/thousands inputs.

## Interface
- FIFO_DEPTH, 4 — number of pending point events; power of two, minimum 2.
- clk  in  1  — system clock.
- resetN  in  1  — asynchronous, active-low reset.
- clear  in  1  — synchronous new-game clear; highest priority.
- add_valid  in  1  — one-cycle point-event strobe.
- add_ones  in  4  — BCD ones digit of the event amount.
- add_tens  in  4  — BCD tens digit of the event amount (amount range 0..99).
- add_ready  out  1  — FIFO not full; an event is accepted only when add_valid=1 and add_ready=1.
- ones, tens, hundreds, thousands  out  5 each  — committed score digits 0..9; bit 4 is always 0.
- busy  out  1  — FSM not in IDLE, or FIFO not empty.
- saturated  out  1  — sticky; score has clamped at 9999.
- dropped  out  1  — sticky; an add_valid arrived while add_ready=0.

## Operation
- Reset state: all digits 0, FIFO empty, FSM in IDLE, add_ready=1, busy=0, saturated=0, dropped=0.
- Input digits greater than 9 are clamped to 9 when pushed.
- FIFO: circular buffer with a count of log2(FIFO_DEPTH)+1 bits.
  - add_ready = (count != FIFO_DEPTH), combinational from count.
  - A push and a pop in the same cycle are both honoured, and count is unchanged.
  - A push while the FIFO is full is dropped and sets dropped.
- FSM states: IDLE, LOAD, ADD0, ADD1, ADD2, ADD3, COMMIT.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD: pop the head into the operand registers, copy the committed digits into the shadow registers, carry=0.
  - ADDn: shadow[n] = shadow[n] + operand[n] + carry. The operand is 0 for n=2 and n=3. If the sum is greater than 9, subtract 10 and set carry=1; otherwise carry=0. Sums use 5-bit arithmetic, maximum 9+9+1=19.
  - ADD3 with carry-out: set the ovf flag.
  - COMMIT: if ovf is set, or saturated is already set, write 9999 to the outputs and set saturated; otherwise write the shadow digits to the outputs. Then go to IDLE.
- Once saturated, later events are still popped and processed, but the outputs remain at 9999.
- clear (synchronous, overrides all other activity):
  - digits go to 0, FIFO flushes, FSM goes to IDLE, and saturated and dropped go to 0;
  - an add_valid in the same cycle is ignored and does not set dropped.

## Timing
- Event accepted at edge E0 with the FSM in IDLE and the FIFO previously empty:
  - E1: IDLE→LOAD;
  - E2: the pop happens in LOAD;
  - E3 through E6: ADD0..ADD3;
  - E7: COMMIT updates the outputs.
- Latency from acceptance to visible score is 7 cycles. Throughput is one event per 7 cycles.
- All outputs are registered, except add_ready (derived from the registered count) and busy (derived from the registered state and count).
- Digit outputs change only on a COMMIT edge, a clear edge, or reset, and all four change on the same edge.
- Reset asserted mid-operation: all state returns to reset values immediately, and pending events are lost.

## Test plan
- Reset, then add 15 (tens=1, ones=5): outputs read 0,0,0,0 through E6 and 0,0,1,5 after E7; busy falls on the same edge.
- Score 0995, add 05: carry ripples across digits, result 1,0,0,0 committed in a single edge with no intermediate value visible.
- Score 9990, add 25: outputs 9,9,9,9 with saturated=1; a further add of 1 keeps 9999; clear returns 0000 with saturated=0.
- Six add_valid pulses of 1 on consecutive cycles while idle:
  - add_ready drops after the FIFO fills and dropped=1;
  - final score equals the number of accepted events: 5 with FIFO_DEPTH=4, because one pop frees a slot during the burst.
- clear asserted while in ADD1 with two events queued: the next edge shows 0000, FIFO empty, and IDLE; no stale commit follows.
- add_ones=12, add_tens=10 pushed: clamped to 99, so a score of 0 becomes 0099.
